// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock divider.
package clk_div_pkg;

  localparam int DIV_MIN = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } div_state_t;

  function automatic logic [31:0] hi_len(input logic [31:0] n);
    return n - (n >> 1);
  endfunction

endpackage

// File: rtl/clk_div_core.sv
// Period counter, waveform compare and tick strobe.
module clk_div_core
  import clk_div_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic [CNT_W-1:0] div_n,
  input  logic             restart,
  input  logic             advance,
  output logic             wrap,
  output logic             clk_out,
  output logic             tick
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_nxt;

  assign cnt_nxt = cnt_q + CNT_W'(1);
  assign wrap    = (cnt_q == div_n - CNT_W'(1));

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else if (restart) begin
      cnt_q   <= '0;
      clk_out <= 1'b1;
      tick    <= 1'b1;
    end else if (advance) begin
      cnt_q   <= cnt_nxt;
      clk_out <= (32'(cnt_nxt) < hi_len(32'(div_n)));
      tick    <= 1'b0;
    end else begin
      cnt_q   <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end
  end

endmodule

// File: rtl/clk_div_prog.sv
// Programmable integer clock divider: run/stop FSM and
// glitch-free divisor update handshake.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             enable,
  input  logic             div_load,
  input  logic [CNT_W-1:0] div_value,
  output logic             div_ack,
  output logic             div_err,
  output logic [CNT_W-1:0] div_active,
  output logic             clk_out,
  output logic             tick,
  output logic             running
);

  localparam longint DIV_MAX = (64'(1) << CNT_W) - 1;
  localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);

  if (DEFAULT_DIV < DIV_MIN || longint'(DEFAULT_DIV) > DIV_MAX) begin : g_bad_default
    $error("clk_div_prog: DEFAULT_DIV out of range");
  end

  div_state_t       state_q;
  div_state_t       state_d;
  logic             restart;
  logic             advance;
  logic             wrap;
  logic             apply;
  logic             load_ok;
  logic             pend_v;
  logic [CNT_W-1:0] pend_q;

  assign load_ok = div_load && (div_value >= CNT_W'(DIV_MIN));
  assign running = (state_q != IDLE);

  // A period boundary only opens a new period if enable is sampled high.
  always_comb begin
    state_d = state_q;
    restart = 1'b0;
    advance = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = RUN;
          restart = 1'b1;
        end
      end
      RUN, STOPPING: begin
        if (wrap) begin
          state_d = enable ? RUN : IDLE;
          restart = enable;
        end else begin
          state_d = enable ? RUN : STOPPING;
          advance = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign apply = pend_v && ((state_q == IDLE) || restart);

  // A load on the apply edge wins the pending slot for the next boundary.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      div_active <= DEF_DIV;
      pend_v     <= 1'b0;
      pend_q     <= '0;
      div_ack    <= 1'b0;
      div_err    <= 1'b0;
    end else begin
      state_q <= state_d;
      div_ack <= apply;
      div_err <= div_load && !load_ok;
      if (apply) begin
        div_active <= pend_q;
        pend_v     <= 1'b0;
      end
      if (load_ok) begin
        pend_q <= div_value;
        pend_v <= 1'b1;
      end
    end
  end

  clk_div_core #(
    .CNT_W(CNT_W)
  ) u_core (
    .clk_in (clk_in),
    .reset  (reset),
    .div_n  (div_active),
    .restart(restart),
    .advance(advance),
    .wrap   (wrap),
    .clk_out(clk_out),
    .tick   (tick)
  );

endmodule
